// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-requester AXI read arbiter.
// Contents: requester count and the arbiter FSM state encoding.
package axi_read_arbiter_pkg;

  // Number of upstream read requesters (0 = icache, 1 = dcache miss)
  localparam int unsigned NUM_REQ = 2;

  // Arbiter FSM: one burst outstanding at a time
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ArbState;

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Two-way round-robin tie-break for the AXI read arbiter.
// Ports:
//   req   [1:0] in  : requester valids
//   last        in  : index granted most recently
//   grant       out : index of the winner (don't-care when req == 0)
module rr_arbiter2
  import axi_read_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic               grant
);

  // On a tie the requester that did not win last time goes; otherwise the lone requester wins
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter (icache = 0, dcache miss = 1) in front of one
// downstream AXI read port, one burst outstanding in total.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   m0_ar_* / m1_ar_*           : requester AR channels (valid/ready/addr/id/len)
//   m0_r_*  / m1_r_*            : requester R channels (valid/ready/data/resp/last/id)
//   s_ar_*                      : downstream AR channel, id = {winner, requester id}
//   s_r_*                       : downstream R channel
//   busy                        : high while a burst is in progress
// Build options:
//   AXI_ARB_FIXED_PRI_EN : dcache (1) always wins ties, no round-robin state
//   DIFFTEST             : assert that returning beats carry the granted requester in s_r_id MSB
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (icache)
  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  input  logic [ID_W-1:0]   m0_ar_id,
  input  logic [LEN_W-1:0]  m0_ar_len,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,
  output logic [ID_W-1:0]   m0_r_id,
  // requester 1 (dcache miss)
  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  input  logic [ID_W-1:0]   m1_ar_id,
  input  logic [LEN_W-1:0]  m1_ar_len,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,
  output logic [ID_W-1:0]   m1_r_id,
  // downstream AR
  output logic              s_ar_valid,
  input  logic              s_ar_ready,
  output logic [ADDR_W-1:0] s_ar_addr,
  output logic [ID_W:0]     s_ar_id,
  output logic [LEN_W-1:0]  s_ar_len,
  // downstream R
  input  logic              s_r_valid,
  output logic              s_r_ready,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [1:0]        s_r_resp,
  input  logic              s_r_last,
  input  logic [ID_W:0]     s_r_id,
  output logic              busy
);

  ArbState             state_q, state_d;
  logic                winner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ID_W-1:0]     id_q;
  logic [LEN_W-1:0]    len_q;
  logic [NUM_REQ-1:0]  req_c;
  logic                grant_c;
  logic                take_c;
  logic                r_ready_c;

  assign req_c  = {m1_ar_valid, m0_ar_valid};
  assign take_c = (state_q == IDLE) && (|req_c);

  // Tie-break selection
`ifdef AXI_ARB_FIXED_PRI_EN
  assign grant_c = req_c[1];
`else
  logic last_grant_q;

  rr_arbiter2 u_rr (
    .req   (req_c),
    .last  (last_grant_q),
    .grant (grant_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (take_c) begin
      last_grant_q <= grant_c;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, loaded in the granting IDLE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q <= 1'b0;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
    end else if (take_c) begin
      winner_q <= grant_c;
      addr_q   <= grant_c ? m1_ar_addr : m0_ar_addr;
      id_q     <= grant_c ? m1_ar_id   : m0_ar_id;
      len_q    <= grant_c ? m1_ar_len  : m0_ar_len;
    end
  end

  assign r_ready_c = winner_q ? m1_r_ready : m0_r_ready;

  // Next state and handshake outputs; everything is held low while rst is high
  always_comb begin
    state_d     = state_q;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    s_ar_valid  = 1'b0;
    s_r_ready   = 1'b0;
    m0_r_valid  = 1'b0;
    m1_r_valid  = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (|req_c) begin
            state_d     = ADDR;
            m0_ar_ready = ~grant_c;
            m1_ar_ready = grant_c;
          end
        end
        ADDR: begin
          busy       = 1'b1;
          s_ar_valid = 1'b1;
          if (s_ar_ready) state_d = DATA;
        end
        DATA: begin
          busy       = 1'b1;
          s_r_ready  = r_ready_c;
          m0_r_valid = s_r_valid & ~winner_q;
          m1_r_valid = s_r_valid & winner_q;
          if (s_r_valid && r_ready_c && s_r_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign s_ar_addr = addr_q;
  assign s_ar_id   = {winner_q, id_q};
  assign s_ar_len  = len_q;

  // R payload is broadcast; only the winner sees r_valid
  assign m0_r_data = s_r_data;
  assign m0_r_resp = s_r_resp;
  assign m0_r_last = s_r_last;
  assign m0_r_id   = s_r_id[ID_W-1:0];
  assign m1_r_data = s_r_data;
  assign m1_r_resp = s_r_resp;
  assign m1_r_last = s_r_last;
  assign m1_r_id   = s_r_id[ID_W-1:0];

  // Routing follows the latched winner, not the returned id MSB
  logic unused_r_id_msb;
  assign unused_r_id_msb = s_r_id[ID_W];

`ifdef DIFFTEST
  always_ff @(posedge clk) begin
    if (!rst && state_q == DATA && s_r_valid) begin
      assert (s_r_id[ID_W] == winner_q)
        else $error("axi_read_arbiter: s_r_id MSB %0b differs from granted requester %0b",
                    s_r_id[ID_W], winner_q);
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized self-checking bench for axi_read_arbiter with a transaction-level model:
// requester queues, a grant rule, and a downstream slave that returns len+1 beats.
module tb_axi_read_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [ADDR_W-1:0] m0_ar_addr, m1_ar_addr, s_ar_addr;
  logic [ID_W-1:0]   m0_ar_id, m1_ar_id, m0_r_id, m1_r_id;
  logic [LEN_W-1:0]  m0_ar_len, m1_ar_len, s_ar_len;
  logic              m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
  logic [DATA_W-1:0] m0_r_data, m1_r_data, s_r_data;
  logic [1:0]        m0_r_resp, m1_r_resp, s_r_resp;
  logic              s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last, busy;
  logic [ID_W:0]     s_ar_id, s_r_id;

  axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
    .m0_ar_id(m0_ar_id), .m0_ar_len(m0_ar_len),
    .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data),
    .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last), .m0_r_id(m0_r_id),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
    .m1_ar_id(m1_ar_id), .m1_ar_len(m1_ar_len),
    .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data),
    .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last), .m1_r_id(m1_r_id),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_id(s_ar_id), .s_ar_len(s_ar_len),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_id(s_r_id),
    .busy(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
  } req_t;

`ifdef AXI_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state
  req_t q0[$], q1[$];
  req_t cur;
  int   owner = -1;     // requester holding the burst, -1 when free
  bit   ar_done;
  int   last = 1;
  int   beats_sent, beats_seen, ar_wait;
  bit   after_rst;
  int   grant_log[$], grant_cyc[$], end_cyc[$];
  int   rst_hits = 0;
  bit   rst_req = 1'b0;

  // Knobs
  int p_ar = 100, p_rv = 100, p_rr0 = 100, p_rr1 = 100, ar_hold = 0, rst_at_beat = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int pick_winner(input bit v0, input bit v1);
    if (v0 && v1) return FIXED ? 1 : 1 - last;
    return v1 ? 1 : 0;
  endfunction

  function automatic int pending();
    return q0.size() + q1.size() + ((owner >= 0) ? 1 : 0);
  endfunction

  task automatic drive_inputs();
    m0_ar_valid = (q0.size() > 0);
    m1_ar_valid = (q1.size() > 0);
    m0_ar_addr  = m0_ar_valid ? q0[0].addr : ADDR_W'($urandom);
    m0_ar_id    = m0_ar_valid ? q0[0].id   : ID_W'($urandom);
    m0_ar_len   = m0_ar_valid ? q0[0].len  : LEN_W'($urandom);
    m1_ar_addr  = m1_ar_valid ? q1[0].addr : ADDR_W'($urandom);
    m1_ar_id    = m1_ar_valid ? q1[0].id   : ID_W'($urandom);
    m1_ar_len   = m1_ar_valid ? q1[0].len  : LEN_W'($urandom);
    m0_r_ready  = ($urandom_range(99) < p_rr0);
    m1_r_ready  = ($urandom_range(99) < p_rr1);
    s_ar_ready  = (ar_wait >= ar_hold) && ($urandom_range(99) < p_ar);
    s_r_valid   = (owner >= 0) && ar_done && ($urandom_range(99) < p_rv);
    s_r_data    = {$urandom, $urandom};
    s_r_resp    = 2'($urandom);
    s_r_last    = (owner >= 0) && (beats_sent == int'(cur.len));
    s_r_id      = (ID_W + 1)'(((owner > 0) ? (1 << ID_W) : 0) + int'(cur.id));
  endtask

  task automatic check_reset_cycle();
    check_eq("rst_m0_ar_ready", 64'(m0_ar_ready), 0);
    check_eq("rst_m1_ar_ready", 64'(m1_ar_ready), 0);
    check_eq("rst_s_ar_valid",  64'(s_ar_valid), 0);
    check_eq("rst_s_r_ready",   64'(s_r_ready), 0);
    check_eq("rst_m0_r_valid",  64'(m0_r_valid), 0);
    check_eq("rst_m1_r_valid",  64'(m1_r_valid), 0);
    check_eq("rst_busy",        64'(busy), 0);
    owner = -1; last = 1; ar_done = 0; after_rst = 1;
  endtask

  task automatic check_and_update();
    int w;
    bit exp_rr, mhs;
    if (after_rst) begin
      check_eq("rst_payload_addr", 64'(s_ar_addr), 0);
      check_eq("rst_payload_id",   64'(s_ar_id), 0);
      check_eq("rst_payload_len",  64'(s_ar_len), 0);
      after_rst = 0;
    end
    if (owner < 0) begin
      w = pick_winner(m0_ar_valid, m1_ar_valid);
      check_eq("idle_m0_ar_ready", 64'(m0_ar_ready), 64'(m0_ar_valid && w == 0));
      check_eq("idle_m1_ar_ready", 64'(m1_ar_ready), 64'(m1_ar_valid && w == 1));
      check_eq("idle_busy", 64'(busy), 0);
      check_eq("idle_s_ar_valid", 64'(s_ar_valid), 0);
      check_eq("idle_r_valid", 64'({m1_r_valid, m0_r_valid, s_r_ready}), 0);
      if (m0_ar_valid || m1_ar_valid) begin
        owner = w; last = w; ar_done = 0; ar_wait = 0; beats_sent = 0; beats_seen = 0;
        cur = (w == 1) ? q1.pop_front() : q0.pop_front();
        grant_log.push_back(w);
        grant_cyc.push_back(cyc);
      end
    end else if (!ar_done) begin
      check_eq("addr_busy", 64'(busy), 1);
      check_eq("addr_s_ar_valid", 64'(s_ar_valid), 1);
      check_eq("addr_s_ar_addr", 64'(s_ar_addr), 64'(cur.addr));
      check_eq("addr_s_ar_id", 64'(s_ar_id), 64'(owner * (1 << ID_W) + int'(cur.id)));
      check_eq("addr_s_ar_len", 64'(s_ar_len), 64'(cur.len));
      check_eq("addr_ar_ready", 64'({m1_ar_ready, m0_ar_ready}), 0);
      check_eq("addr_r_side", 64'({m1_r_valid, m0_r_valid, s_r_ready}), 0);
      if (s_ar_ready) ar_done = 1;
      else ar_wait++;
    end else begin
      exp_rr = (owner == 1) ? m1_r_ready : m0_r_ready;
      check_eq("data_busy", 64'(busy), 1);
      check_eq("data_s_ar_valid", 64'(s_ar_valid), 0);
      check_eq("data_ar_ready", 64'({m1_ar_ready, m0_ar_ready}), 0);
      check_eq("data_s_r_ready", 64'(s_r_ready), 64'(exp_rr));
      check_eq("data_m0_r_valid", 64'(m0_r_valid), 64'(owner == 0 && s_r_valid));
      check_eq("data_m1_r_valid", 64'(m1_r_valid), 64'(owner == 1 && s_r_valid));
      if (s_r_valid) begin
        check_eq("data_r_data", (owner == 1) ? m1_r_data : m0_r_data, s_r_data);
        check_eq("data_r_resp", 64'((owner == 1) ? m1_r_resp : m0_r_resp), 64'(s_r_resp));
        check_eq("data_r_last", 64'((owner == 1) ? m1_r_last : m0_r_last), 64'(s_r_last));
        check_eq("data_r_id", 64'((owner == 1) ? m1_r_id : m0_r_id), 64'(cur.id));
      end
      mhs = (owner == 1) ? (m1_r_valid && m1_r_ready) : (m0_r_valid && m0_r_ready);
      if (mhs) beats_seen++;
      if (s_r_valid && exp_rr) begin
        beats_sent++;
        if (s_r_last) begin
          check_eq("burst_beats", 64'(beats_seen), 64'(int'(cur.len) + 1));
          end_cyc.push_back(cyc);
          owner = -1;
        end else if (rst_at_beat != 0 && beats_seen == rst_at_beat) begin
          rst_req = 1; rst_at_beat = 0; rst_hits++;
        end
      end
    end
  endtask

  task automatic tick();
    rst = rst_req;
    rst_req = 0;
    drive_inputs();
    #4;
    if (rst) check_reset_cycle();
    else check_and_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_req = 1;
    tick();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((pending() > 0 || rst_req) && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("drained", 64'(pending()), 0);
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); end_cyc.delete();
  endtask

  task automatic set_knobs(input int ar, input int rv, input int rr0, input int rr1, input int hold);
    p_ar = ar; p_rv = rv; p_rr0 = rr0; p_rr1 = rr1; ar_hold = hold;
  endtask

  initial begin
    rst = 1'b1;
    cur = '0;
    @(posedge clk);
    #1;
    // Reset state with a request already waiting
    q0.push_back('{addr: 32'h1000_0000, id: 4'd1, len: 8'd0});
    rst_req = 1; tick();
    rst_req = 1; tick();
    run_until_idle(50);

    // Single request from m0
    clear_logs(); set_knobs(100, 100, 100, 100, 0);
    q0.push_back('{addr: 32'h8000_0000, id: 4'd3, len: 8'd7});
    run_until_idle(100);
    check_eq("single_grants", 64'(grant_log.size()), 1);
    check_eq("single_winner", 64'(grant_log[0]), 0);
    tick();

    // Tie right after reset
    do_reset(); clear_logs(); set_knobs(100, 80, 100, 100, 0);
    q0.push_back('{addr: 32'h0000_1000, id: 4'd5, len: 8'd3});
    q1.push_back('{addr: 32'h0000_2000, id: 4'd9, len: 8'd2});
    run_until_idle(100);
    check_eq("tie_first", 64'(grant_log[0]), FIXED ? 1 : 0);
    check_eq("tie_second", 64'(grant_log[1]), FIXED ? 0 : 1);

    // Sustained contention
    do_reset(); clear_logs(); set_knobs(70, 70, 90, 90, 0);
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{addr: 32'(32'h100 * i), id: 4'(i), len: 8'(i % 3)});
      q1.push_back('{addr: 32'(32'h8000 + 32'h100 * i), id: 4'(i + 8), len: 8'(1)});
    end
    run_until_idle(400);
    for (int i = 0; i < 4; i++) check_eq("contention_grant", 64'(grant_log[i]), FIXED ? 1 : 64'(i % 2));

    // AR backpressure and m1 r_ready toggling
    do_reset(); clear_logs(); set_knobs(100, 100, 100, 50, 5);
    q1.push_back('{addr: 32'hCAFE_0040, id: 4'd6, len: 8'd7});
    run_until_idle(200);
    check_eq("bp_end", 64'(end_cyc.size()), 1);
    check_eq("bp_ar_stall", 64'(end_cyc[0] - grant_cyc[0] >= 7), 1);
    set_knobs(100, 100, 100, 100, 0);

    // Reset during DATA after beat 3 of 8
    do_reset(); clear_logs();
    q0.push_back('{addr: 32'h4000_0000, id: 4'd2, len: 8'd7});
    rst_at_beat = 3;
    run_until_idle(100);
    check_eq("mid_rst_hit", 64'(rst_hits), 1);
    check_eq("mid_rst_no_end", 64'(end_cyc.size()), 0);
    tick();
    rst_at_beat = 0;

    // Single-beat burst followed immediately by the other requester
    do_reset(); clear_logs();
    q0.push_back('{addr: 32'h0000_0040, id: 4'd7, len: 8'd0});
    q1.push_back('{addr: 32'h0000_0080, id: 4'd4, len: 8'd0});
    run_until_idle(50);
    check_eq("single_beat_regrant_gap", 64'(grant_cyc[1] - end_cyc[0]), 1);

    // Random traffic
    do_reset(); clear_logs();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        set_knobs(40 + $urandom_range(60), 30 + $urandom_range(70),
                  30 + $urandom_range(70), 30 + $urandom_range(70), $urandom_range(3));
      if (q0.size() < 3 && $urandom_range(99) < 8)
        q0.push_back('{addr: $urandom, id: ID_W'($urandom), len: LEN_W'($urandom_range(5))});
      if (q1.size() < 3 && $urandom_range(99) < 8)
        q1.push_back('{addr: $urandom, id: ID_W'($urandom), len: LEN_W'($urandom_range(5))});
      tick();
    end
    set_knobs(100, 100, 100, 100, 0);
    run_until_idle(2000);
    check_eq("random_bursts_done", 64'(end_cyc.size() > 10), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
